// File: rtl/stride_prefetcher_p.sv
// PC-indexed stride prefetcher: reference table, burst generator and a single-slot prefetch output.
// Define STRIDE_PF_FILTER_EN to build the outstanding-request-list duplicate filter.
module stride_prefetcher_p #(
    parameter int ADDR_W    = 16,
    parameter int PC_W      = 16,
    parameter int IDX_W     = 5,
    parameter int DEGREE    = 2,
    parameter int ORL_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_valid,
    input  logic [PC_W-1:0]   acc_pc,
    input  logic [ADDR_W-1:0] acc_addr,
    output logic              pf_valid,
    output logic [ADDR_W-1:0] pf_addr,
    input  logic              pf_ready,
    output logic [15:0]       drop_cnt
);
    localparam int NUM_ENT = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_TRANSIENT = 2'd1,
        ST_STEADY    = 2'd2,
        ST_NOPRED    = 2'd3
    } st_e;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] prev;
        logic [ADDR_W-1:0] stride;
        st_e               st;
    } entry_t;

    if (DEGREE < 1 || DEGREE > 8 || ORL_DEPTH < 1) begin : g_param_chk
        $error("stride_prefetcher_p: DEGREE must be 1..8 and ORL_DEPTH >= 1");
    end

    // ---------------- reference table ----------------
    entry_t            tbl_q [NUM_ENT];
    entry_t            tbl_d [NUM_ENT];
    entry_t            cur;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit;
    logic              match;
    logic              trig;
    logic [ADDR_W-1:0] delta;
    st_e               nxt_st;

    assign idx = acc_pc[IDX_W-1:0];
    assign tag = acc_pc[PC_W-1:IDX_W];

    always_comb begin
        cur   = tbl_q[idx];
        hit   = acc_valid && cur.valid && (cur.tag == tag);
        delta = acc_addr - cur.prev;
        match = (delta == cur.stride);
        case (cur.st)
            ST_INIT:      nxt_st = ST_TRANSIENT;
            ST_TRANSIENT: nxt_st = match ? ST_STEADY : ST_NOPRED;
            ST_STEADY:    nxt_st = match ? ST_STEADY : ST_INIT;
            default:      nxt_st = match ? ST_TRANSIENT : ST_NOPRED;
        endcase
        trig  = hit && (nxt_st == ST_STEADY) && (delta != '0);
        tbl_d = tbl_q;
        if (acc_valid) begin
            if (hit) tbl_d[idx] = '{valid: 1'b1, tag: tag, prev: acc_addr, stride: delta, st: nxt_st};
            else     tbl_d[idx] = '{valid: 1'b1, tag: tag, prev: acc_addr, stride: '0, st: ST_INIT};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENT; i++) tbl_q[i] <= '0;
        end else begin
            tbl_q <= tbl_d;
        end
    end

    // ---------------- burst generator and output slot ----------------
    logic [ADDR_W-1:0] base_q, base_d, gstride_q, gstride_d, cand;
    logic [CNT_W-1:0]  k_q, k_d, rem_q, rem_d;
    logic              pf_valid_q, pf_valid_d;
    logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
    logic              slot_free, eval, drop, push;

    assign slot_free = !pf_valid_q || pf_ready;
    assign eval      = slot_free && (rem_q != '0);
    assign cand      = base_q + ADDR_W'(k_q) * gstride_q;
    assign push      = eval && !drop;

    // A trigger overrides the advance, so a coinciding evaluation still used the old burst.
    always_comb begin
        base_d     = base_q;
        gstride_d  = gstride_q;
        k_d        = k_q;
        rem_d      = rem_q;
        pf_valid_d = pf_valid_q;
        pf_addr_d  = pf_addr_q;
        if (eval) begin
            k_d   = k_q + CNT_W'(1);
            rem_d = rem_q - CNT_W'(1);
        end
        if (trig) begin
            base_d    = acc_addr;
            gstride_d = delta;
            k_d       = CNT_W'(1);
            rem_d     = CNT_W'(DEGREE);
        end
        if (slot_free) begin
            pf_valid_d = push;
            if (push) pf_addr_d = cand;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            gstride_q  <= '0;
            k_q        <= '0;
            rem_q      <= '0;
            pf_valid_q <= 1'b0;
            pf_addr_q  <= '0;
        end else begin
            base_q     <= base_d;
            gstride_q  <= gstride_d;
            k_q        <= k_d;
            rem_q      <= rem_d;
            pf_valid_q <= pf_valid_d;
            pf_addr_q  <= pf_addr_d;
        end
    end

    assign pf_valid = pf_valid_q;
    assign pf_addr  = pf_addr_q;

`ifdef STRIDE_PF_FILTER_EN
    // ---------------- outstanding request list ----------------
    localparam int ORL_PW = (ORL_DEPTH > 1) ? $clog2(ORL_DEPTH) : 1;

    logic [ADDR_W-1:0]    orl_q [ORL_DEPTH];
    logic [ADDR_W-1:0]    orl_d [ORL_DEPTH];
    logic [ORL_DEPTH-1:0] orl_vld_q, orl_vld_d;
    logic [ORL_PW-1:0]    orl_wp_q, orl_wp_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop = 1'b0;
        for (int i = 0; i < ORL_DEPTH; i++) begin
            if (orl_vld_q[i] && (orl_q[i] == cand)) drop = 1'b1;
        end
    end

    always_comb begin
        orl_d      = orl_q;
        orl_vld_d  = orl_vld_q;
        orl_wp_d   = orl_wp_q;
        drop_cnt_d = drop_cnt_q;
        if (eval && drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
        if (push) begin
            orl_d[orl_wp_q]     = cand;
            orl_vld_d[orl_wp_q] = 1'b1;
            orl_wp_d = (orl_wp_q == ORL_PW'(ORL_DEPTH - 1)) ? '0 : orl_wp_q + ORL_PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ORL_DEPTH; i++) orl_q[i] <= '0;
            orl_vld_q  <= '0;
            orl_wp_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            orl_q      <= orl_d;
            orl_vld_q  <= orl_vld_d;
            orl_wp_q   <= orl_wp_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop     = 1'b0;
    assign drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_stride_prefetcher_p.sv
// Randomized + directed bench for stride_prefetcher_p; a candidate-list model feeds a scoreboard queue.
module tb_stride_prefetcher_p;
    localparam int AW = 16, PW = 16, IW = 5, DEG = 2, ORLD = 8;
    localparam int NE = 1 << IW;
`ifdef STRIDE_PF_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          acc_valid = 1'b0;
    logic [PW-1:0] acc_pc = '0;
    logic [AW-1:0] acc_addr = '0;
    logic          pf_ready = 1'b0;
    logic          pf_valid;
    logic [AW-1:0] pf_addr;
    logic [15:0]   drop_cnt;

    stride_prefetcher_p #(.ADDR_W(AW), .PC_W(PW), .IDX_W(IW), .DEGREE(DEG), .ORL_DEPTH(ORLD)) dut (
        .clk(clk), .rst(rst), .acc_valid(acc_valid), .acc_pc(acc_pc), .acc_addr(acc_addr),
        .pf_valid(pf_valid), .pf_addr(pf_addr), .pf_ready(pf_ready), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int misses  = 0;
    int acc_cnt = 0;

    // reference model: table of per-PC history plus a list of pending candidate addresses
    bit            m_tv   [NE];
    logic [PW-1:0] m_tg   [NE];
    logic [AW-1:0] m_prev [NE];
    logic [AW-1:0] m_str  [NE];
    int            m_st   [NE];
    int nx_match [4] = '{1, 2, 2, 1};
    int nx_miss  [4] = '{1, 3, 0, 3};
    logic [AW-1:0] pend [$];
    logic [AW-1:0] orl_m [$];
    logic [AW-1:0] exp_q [$];
    bit            m_valid = 1'b0;
    logic [15:0]   m_drops = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NE; i++) m_tv[i] = 1'b0;
        pend.delete();
        orl_m.delete();
        exp_q.delete();
        m_valid = 1'b0;
        m_drops = '0;
    endfunction

    function automatic bit in_orl(input logic [AW-1:0] a);
        foreach (orl_m[i]) if (orl_m[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the specified behaviour, using the inputs presented before the edge.
    function automatic void model_edge();
        logic [AW-1:0] c, d;
        int i, ns;
        if (rst) return;
        if (!m_valid || pf_ready) begin
            m_valid = 1'b0;
            if (pend.size() > 0) begin
                c = pend.pop_front();
                if (FILTER && in_orl(c)) begin
                    if (m_drops != 16'hFFFF) m_drops++;
                end else begin
                    m_valid = 1'b1;
                    exp_q.push_back(c);
                    orl_m.push_back(c);
                    if (orl_m.size() > ORLD) void'(orl_m.pop_front());
                end
            end
        end
        if (acc_valid) begin
            i = int'(acc_pc) % NE;
            if (!m_tv[i] || m_tg[i] != (acc_pc >> IW)) begin
                m_tv[i] = 1'b1; m_tg[i] = acc_pc >> IW;
                m_prev[i] = acc_addr; m_str[i] = '0; m_st[i] = 0;
            end else begin
                d  = acc_addr - m_prev[i];
                ns = (d == m_str[i]) ? nx_match[m_st[i]] : nx_miss[m_st[i]];
                if (ns == 2 && d != '0) begin
                    pend.delete();
                    for (int k = 1; k <= DEG; k++) pend.push_back(acc_addr + AW'(k) * d);
                end
                m_prev[i] = acc_addr; m_str[i] = d; m_st[i] = ns;
            end
        end
    endfunction

    // monitor: per-cycle output-valid and drop-count checks, address checked on each handshake
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            chk("pf_valid", {31'd0, pf_valid}, {31'd0, m_valid});
            chk("drop_cnt", {16'd0, drop_cnt}, {16'd0, m_drops});
            if (pf_valid && pf_ready) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pf", {16'd0, pf_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pf_addr", {16'd0, pf_addr}, {16'd0, e});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic acc(input logic [PW-1:0] pc, input logic [AW-1:0] a);
        acc_valid = 1'b1; acc_pc = pc; acc_addr = a;
        tick();
        acc_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_pf_valid", {31'd0, pf_valid}, 32'd0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    logic [AW-1:0] r_last [4];
    logic [AW-1:0] r_str  [4];
    logic [PW-1:0] r_pc   [4] = '{16'h0010, 16'h0030, 16'h0045, 16'h1047};
    logic [AW-1:0] st_tab [5] = '{16'h0004, 16'h0008, 16'hFFFC, 16'h0000, 16'h0040};

    initial begin
        int base, j;
        // power-on reset, checked before any clock edge
        #1 rst = 1'b1;
        model_reset();
        #1;
        chk("por_pf_valid", {31'd0, pf_valid}, 32'd0);
        chk("por_pf_addr", {16'd0, pf_addr}, 32'd0);
        chk("por_drop_cnt", {16'd0, drop_cnt}, 32'd0);
        tick(); tick();
        rst = 1'b0;

        // training with pf_ready high, then a re-trigger overlapping issued addresses
        pf_ready = 1'b1;
        acc(16'h0010, 16'h0100); acc(16'h0010, 16'h0104); acc(16'h0010, 16'h0108);
        tick();
        @(negedge clk);
        chk("train_first_v", {31'd0, pf_valid}, 32'd1);
        chk("train_first", {16'd0, pf_addr}, 32'h010C);
        tick(); @(negedge clk);
        chk("train_second", {16'd0, pf_addr}, 32'h0110);
        tick(); @(negedge clk);
        chk("train_idle", {31'd0, pf_valid}, 32'd0);
        acc(16'h0010, 16'h010C);
        tick(); tick(); @(negedge clk);
        chk("filter_next", {16'd0, pf_addr}, 32'h0114);
        chk("filter_drops", {16'd0, drop_cnt}, FILTER ? 32'd1 : 32'd0);
        tick();

        // backpressure: first prefetch held for 5 cycles, next one a cycle after release
        do_reset();
        pf_ready = 1'b0;
        acc(16'h0010, 16'h0100); acc(16'h0010, 16'h0104); acc(16'h0010, 16'h0108);
        tick();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_hold", {15'd0, pf_valid, pf_addr}, {15'd0, 1'b1, 16'h010C});
            tick();
        end
        pf_ready = 1'b1;
        tick(); @(negedge clk);
        chk("bp_release", {15'd0, pf_valid, pf_addr}, {15'd0, 1'b1, 16'h0110});
        tick();

        // asynchronous reset mid-burst, then replay restarts training from INIT
        do_reset();
        pf_ready = 1'b0;
        acc(16'h0010, 16'h0100); acc(16'h0010, 16'h0104); acc(16'h0010, 16'h0108);
        tick();
        @(negedge clk);
        do_reset();
        pf_ready = 1'b1;
        base = acc_cnt;
        acc(16'h0010, 16'h0104); acc(16'h0010, 16'h0108);
        repeat (4) tick();
        chk("replay_no_pf", acc_cnt - base, 32'd0);
        acc(16'h0010, 16'h010C);
        tick(); @(negedge clk);
        chk("replay_pf", {15'd0, pf_valid, pf_addr}, {15'd0, 1'b1, 16'h0110});
        tick();

        // irregular pattern: only the third access triggers
        do_reset();
        base = acc_cnt;
        acc(16'h0020, 16'h0200); acc(16'h0020, 16'h0208); acc(16'h0020, 16'h0210);
        acc(16'h0020, 16'h0300); acc(16'h0020, 16'h0304);
        repeat (6) tick();
        chk("irregular_count", acc_cnt - base, 32'd2);

        // aliasing PCs on one index, and address wrap
        do_reset();
        acc(16'h0010, 16'h0100); acc(16'h0010, 16'h0104);
        acc(16'h0030, 16'hFFF8); acc(16'h0030, 16'hFFFC); acc(16'h0030, 16'h0000);
        tick(); @(negedge clk);
        chk("wrap_first", {15'd0, pf_valid, pf_addr}, {15'd0, 1'b1, 16'h0004});
        tick(); @(negedge clk);
        chk("wrap_second", {15'd0, pf_valid, pf_addr}, {15'd0, 1'b1, 16'h0008});
        tick();

        // randomized traffic with random backpressure
        do_reset();
        for (int n = 0; n < 4; n++) begin
            r_last[n] = AW'($urandom);
            r_str[n]  = st_tab[$urandom_range(0, 4)];
        end
        for (int n = 0; n < 3000; n++) begin
            j = $urandom_range(0, 3);
            if ($urandom_range(0, 9) < 2) r_str[j] = st_tab[$urandom_range(0, 4)];
            r_last[j] = r_last[j] + r_str[j];
            acc_valid = ($urandom_range(0, 9) < 6);
            acc_pc    = r_pc[j];
            acc_addr  = r_last[j];
            pf_ready  = ($urandom_range(0, 9) < 7);
            tick();
        end
        acc_valid = 1'b0;
        pf_ready  = 1'b1;
        repeat (20) tick();
        chk("drain_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
